// File: rtl/tower_attack_arbiter.sv
// Round-robin arbiter sharing one tower damage port among several attacking units.
// Issues at most one one-cycle damage strobe per decision, then enforces a cooldown
// measured in game ticks. Issuing stops for good once the tower dies, and everything
// returns to idle when the level ends.
module tower_attack_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DMG_W     = 8,
    parameter int unsigned COOLDOWN  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       game_tick,
    input  logic                       level_active,
    input  logic                       tower_dead,
    input  logic [NUM_UNITS-1:0]       req,
    input  logic [NUM_UNITS*DMG_W-1:0] dmg_in,
    output logic [NUM_UNITS-1:0]       grant,
    output logic [DMG_W-1:0]           damage_out,
    output logic                       attack_scen,
    output logic                       busy,
    output logic [15:0]                hits_total
);

    localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned HIT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_COOL  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t                 state_q,       state_d;
    logic [IDX_W-1:0]       rr_ptr_q,      rr_ptr_d;
    logic [CNT_W-1:0]       cool_cnt_q,    cool_cnt_d;
    logic [NUM_UNITS-1:0]   grant_q,       grant_d;
    logic [DMG_W-1:0]       damage_out_q,  damage_out_d;
    logic                   attack_scen_q, attack_scen_d;
    logic                   busy_q,        busy_d;
    logic [HIT_W-1:0]       hits_total_q,  hits_total_d;

    logic                   sel_found_c;
    logic [IDX_W-1:0]       sel_idx_c;
    logic [IDX_W-1:0]       sel_next_c;

    // Round-robin scan starting at rr_ptr; first pending request wins.
    always_comb begin
        int unsigned cand;
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_UNITS) begin
                cand = cand - NUM_UNITS;
            end
            if (!sel_found_c && req[IDX_W'(cand)]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(cand);
            end
        end
        if (32'(sel_idx_c) + 32'd1 >= NUM_UNITS) begin
            sel_next_c = '0;
        end else begin
            sel_next_c = sel_idx_c + IDX_W'(1);
        end
    end

    // Next-state and registered-output computation; outputs reflect the state being entered.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cool_cnt_d    = cool_cnt_q;
        grant_d       = '0;
        damage_out_d  = damage_out_q;
        attack_scen_d = 1'b0;
        busy_d        = 1'b0;
        hits_total_d  = hits_total_q;

        if (state_q == ST_IDLE) begin
            hits_total_d = '0;
            cool_cnt_d   = '0;
            if (level_active) begin
                state_d = ST_ARB;
            end
        end else if (!level_active) begin
            // Level over: abandon any pending work and clear the per-level count.
            state_d      = ST_IDLE;
            hits_total_d = '0;
            cool_cnt_d   = '0;
        end else if (tower_dead) begin
            state_d    = ST_HALT;
            cool_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (game_tick && sel_found_c) begin
                        state_d       = ST_ISSUE;
                        grant_d       = NUM_UNITS'(1) << sel_idx_c;
                        damage_out_d  = dmg_in[32'(sel_idx_c) * DMG_W +: DMG_W];
                        attack_scen_d = 1'b1;
                        busy_d        = 1'b1;
                        rr_ptr_d      = sel_next_c;
                        if (hits_total_q != {HIT_W{1'b1}}) begin
                            hits_total_d = hits_total_q + HIT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (COOLDOWN == 0) begin
                        state_d = ST_ARB;
                    end else begin
                        state_d    = ST_COOL;
                        cool_cnt_d = CNT_W'(COOLDOWN);
                        busy_d     = 1'b1;
                    end
                end
                ST_COOL: begin
                    busy_d = 1'b1;
                    if (game_tick) begin
                        if (cool_cnt_q <= CNT_W'(1)) begin
                            state_d    = ST_ARB;
                            cool_cnt_d = '0;
                            busy_d     = 1'b0;
                        end else begin
                            cool_cnt_d = cool_cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // HALT (and any stray encoding) parks until the level ends.
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            cool_cnt_q    <= '0;
            grant_q       <= '0;
            damage_out_q  <= '0;
            attack_scen_q <= 1'b0;
            busy_q        <= 1'b0;
            hits_total_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cool_cnt_q    <= cool_cnt_d;
            grant_q       <= grant_d;
            damage_out_q  <= damage_out_d;
            attack_scen_q <= attack_scen_d;
            busy_q        <= busy_d;
            hits_total_q  <= hits_total_d;
        end
    end

    assign grant       = grant_q;
    assign damage_out  = damage_out_q;
    assign attack_scen = attack_scen_q;
    assign busy        = busy_q;
    assign hits_total  = hits_total_q;

endmodule
